lifo_stack: RTL and testbench
=============================

# lifo_stack

Synchronous last-in/first-out stack of `N` words of `WL` bits, used as the processor's hardware return/operand stack in the pipelined datapath. It accepts one push or one pop per clock, exposes the stack pointer and full/empty status, reports illegal requests, and registers the most recently popped word on `data`.

## Interface
- `N`, default 32: stack depth in words; power of two, at least 2.
- `WL`, default 32: word width in bits.
- `CLK` input 1: single clock; all state updates on the rising edge.
- `RESET` input 1: asynchronous, active-low reset.
- `push` input 1: push request; `dio` is written on the rising edge.
- `pop` input 1: pop request; the top word is removed and loaded into `data`.
- `dio` input WL: word to push.
- `sp` output $clog2(N) (5 at N=32): stack pointer, the index of the next free slot, equal to the occupancy modulo N.
- `full` output 1: occupancy equals N.
- `empty` output 1: occupancy equals 0.
- `error` output 1: registered pulse flagging an illegal request in the previous cycle.
- `data` output WL: last successfully popped word.

## Operation
- Storage is an N-entry register array indexed by `sp`. Internal occupancy is tracked with $clog2(N)+1 bits, or with `sp` plus a full flag.
- Push only, not full: `mem[sp] <= dio`, `sp <= sp+1` (wraps to 0 when it becomes full), `empty` clears, and `full` sets when occupancy reaches N.
- Pop only, not empty: `data <= mem[sp-1]` (modulo N), `sp <= sp-1`, `full` clears, and `empty` sets when occupancy reaches 0.
- Push while full: ignored. Memory, `sp`, `full` and `data` are unchanged; `error` is 1 in the next cycle.
- Pop while empty: ignored. `data` holds; `error` is 1 in the next cycle.
- Push and pop together: no operation, and `error` is 1 in the next cycle.
- Neither request: all state holds; `error` is 0 in the next cycle.
- `error` is recomputed every cycle and is not sticky.
- Memory contents are not reset; only pointer and status registers are reset.

## Timing
- During reset: `sp`=0, `empty`=1, `full`=0, `error`=0, `data`=0.
- All outputs are registered, so there is no combinational path from inputs to outputs.
- `sp`, `full`, `empty`, `data` and `error` reflect a request on the same rising edge that samples it, so they are visible one cycle after the request is presented.
- Throughput is one operation per cycle. Back-to-back pushes or pops need no idle cycles.
- A pop immediately after a push returns the word just pushed.
- Reset asserted mid-operation aborts the current operation and forces the reset values immediately. The first operation after deassertion is taken on the next rising edge with `RESET`=1.
- At N=32, `sp`=0 is shared by the empty and full states; `full` and `empty` disambiguate.

## Structure
- No shared package is needed.
- Optional: the `error` cause encoding (none/overflow/underflow/conflict) goes in the processor's common package if a later revision exposes it.
- The storage array is a natural sub-module, `stack_ram`: N×WL, one synchronous write port, one asynchronous read port.
- The pointer/flag control stays in the top level.

## Test plan
- Reset: hold `RESET`=0, then release. Expect `sp`=0, `empty`=1, `full`=0, `error`=0, `data`=0.
- Push 1,2,4,5,7,4 on consecutive cycles, then pop once. Expect `sp`=6 then 5, and `data`=4.
- Continue: push 3, push 1, then pop ×5. Expect `data` sequence 1,3,7,5,4 and final `sp`=2; then push 2, expect `sp`=3.
- Fill: push N words 0..N-1. Expect `full`=1 and `sp`=0. Push once more: expect `error`=1 for one cycle, `sp`=0, `full`=1; then a pop returns N-1.
- Underflow: from empty, pop. Expect `error`=1, `empty`=1, `sp`=0, `data` unchanged. Assert push and pop together: expect `error`=1 and no state change.
- Assert reset after three pushes. Expect immediate `sp`=0, `empty`=1, `data`=0; then push 9 and pop, expect `data`=9.

Source files
------------

// File: rtl/lifo_stack_pkg.sv
// Shared constants and request decode type for the LIFO stack.
package lifo_stack_pkg;

  localparam int unsigned DEF_N  = 32;
  localparam int unsigned DEF_WL = 32;

  // One-hot-free decode of the {push, pop} request pair
  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_BOTH = 2'd3
  } op_t;

endpackage

// File: rtl/lifo_stack_if.sv
// Request/status bundle between a stack user (master) and the stack (slave).
interface lifo_stack_if
  import lifo_stack_pkg::*;
#(
  parameter int unsigned N  = DEF_N,
  parameter int unsigned WL = DEF_WL
) ();

  localparam int unsigned AW = $clog2(N);

  logic          push;
  logic          pop;
  logic [WL-1:0] dio;
  logic [AW-1:0] sp;
  logic          full;
  logic          empty;
  logic          error;
  logic [WL-1:0] data;

  modport master (output push, pop, dio, input sp, full, empty, error, data);
  modport slave  (input push, pop, dio, output sp, full, empty, error, data);

endinterface

// File: rtl/lifo_stack_ram.sv
// stack_ram storage: N x WL words, synchronous write, asynchronous read.
module lifo_stack_ram #(
  parameter int unsigned N  = 32,
  parameter int unsigned WL = 32,
  parameter int unsigned AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [WL-1:0] wr_word,
  input  logic [AW-1:0] rd_addr,
  output logic [WL-1:0] rd_word_c
);

  logic [WL-1:0] mem [N];

  // Write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_word;
  end

  assign rd_word_c = mem[rd_addr];

endmodule

// File: rtl/lifo_stack.sv
// Hardware LIFO stack: one push or pop per cycle, registered status and popped word.
module lifo_stack
  import lifo_stack_pkg::*;
#(
  parameter int unsigned N  = DEF_N,
  parameter int unsigned WL = DEF_WL
) (
  input logic         CLK,
  input logic         RESET,
  lifo_stack_if.slave bus
);

  localparam int unsigned AW = $clog2(N);

  op_t           op;
  logic [AW-1:0] sp_q, sp_n;
  logic          full_q, full_n;
  logic          empty_q, empty_n;
  logic          error_q, error_n;
  logic [WL-1:0] data_q, data_n;
  logic          wr_en_c;
  logic [AW-1:0] rd_addr_c;
  logic [WL-1:0] rd_word_c;

  // Top of stack sits one below the next free slot, wrapping when full
  assign rd_addr_c = sp_q - AW'(1);

  lifo_stack_ram #(.N(N), .WL(WL), .AW(AW)) u_stack_ram (
    .clk       (CLK),
    .wr_en     (wr_en_c),
    .wr_addr   (sp_q),
    .wr_word   (bus.dio),
    .rd_addr   (rd_addr_c),
    .rd_word_c (rd_word_c)
  );

  // Decode the request pair
  always_comb begin
    op = OP_IDLE;
    case ({bus.push, bus.pop})
      2'b10:   op = OP_PUSH;
      2'b01:   op = OP_POP;
      2'b11:   op = OP_BOTH;
      default: op = OP_IDLE;
    endcase
  end

  // Next pointer/flags; illegal requests leave state untouched and raise error
  always_comb begin
    sp_n    = sp_q;
    full_n  = full_q;
    empty_n = empty_q;
    data_n  = data_q;
    error_n = 1'b0;
    wr_en_c = 1'b0;
    case (op)
      OP_PUSH: begin
        if (full_q) begin
          error_n = 1'b1;
        end else begin
          wr_en_c = 1'b1;
          sp_n    = sp_q + AW'(1);
          full_n  = (sp_q == AW'(N - 1));
          empty_n = 1'b0;
        end
      end
      OP_POP: begin
        if (empty_q) begin
          error_n = 1'b1;
        end else begin
          data_n  = rd_word_c;
          sp_n    = rd_addr_c;
          full_n  = 1'b0;
          empty_n = (sp_q == AW'(1));
        end
      end
      OP_BOTH: error_n = 1'b1;
      default: error_n = 1'b0;
    endcase
  end

  // Pointer, status and popped-word registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sp_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      error_q <= 1'b0;
      data_q  <= '0;
    end else begin
      sp_q    <= sp_n;
      full_q  <= full_n;
      empty_q <= empty_n;
      error_q <= error_n;
      data_q  <= data_n;
    end
  end

  assign bus.sp    = sp_q;
  assign bus.full  = full_q;
  assign bus.empty = empty_q;
  assign bus.error = error_q;
  assign bus.data  = data_q;

endmodule

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack: queue-based reference model plus directed literals.
module tb_lifo_stack;

  localparam int unsigned N  = 32;
  localparam int unsigned WL = 32;

  logic CLK;
  logic RESET;

  int checks = 0;
  int errors = 0;

  lifo_stack_if #(.N(N), .WL(WL)) ifc ();

  lifo_stack #(.N(N), .WL(WL)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (ifc.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: a plain queue of words
  logic [WL-1:0] m_q [$];
  logic [WL-1:0] m_data;
  logic          m_err;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_q.delete();
      m_data = '0;
      m_err  = 1'b0;
    end else if (ifc.push && ifc.pop) begin
      m_err = 1'b1;
    end else if (ifc.push) begin
      if (m_q.size() == int'(N)) m_err = 1'b1;
      else begin
        m_q.push_back(ifc.dio);
        m_err = 1'b0;
      end
    end else if (ifc.pop) begin
      if (m_q.size() == 0) m_err = 1'b1;
      else begin
        m_data = m_q.pop_back();
        m_err  = 1'b0;
      end
    end else begin
      m_err = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge CLK) begin
    chk("cyc_sp",    32'(ifc.sp),    32'(m_q.size() % int'(N)));
    chk("cyc_full",  32'(ifc.full),  32'(m_q.size() == int'(N)));
    chk("cyc_empty", 32'(ifc.empty), 32'(m_q.size() == 0));
    chk("cyc_error", 32'(ifc.error), 32'(m_err));
    chk("cyc_data",  32'(ifc.data),  32'(m_data));
  end

  task automatic drive(input logic p, input logic q, input logic [WL-1:0] d);
    @(negedge CLK);
    ifc.push = p;
    ifc.pop  = q;
    ifc.dio  = d;
  endtask

  task automatic push(input logic [WL-1:0] d); drive(1'b1, 1'b0, d); endtask
  task automatic pop();  drive(1'b0, 1'b1, '0); endtask
  task automatic idle(); drive(1'b0, 1'b0, '0); endtask

  initial begin
    RESET    = 1'b0;
    ifc.push = 1'b0;
    ifc.pop  = 1'b0;
    ifc.dio  = '0;
    repeat (3) @(negedge CLK);
    chk("rst_sp",    32'(ifc.sp),    32'd0);
    chk("rst_empty", 32'(ifc.empty), 32'd1);
    chk("rst_full",  32'(ifc.full),  32'd0);
    chk("rst_error", 32'(ifc.error), 32'd0);
    chk("rst_data",  ifc.data,       32'd0);
    RESET = 1'b1;

    // Back-to-back pushes then one pop
    push(1); push(2); push(4); push(5); push(7); push(4);
    pop();
    chk("sp_after_6push", 32'(ifc.sp), 32'd6);
    idle();
    chk("sp_after_pop", 32'(ifc.sp), 32'd5);
    chk("data_pop1",    ifc.data,    32'd4);

    // Interleaved pushes, then five consecutive pops
    push(3); push(1);
    pop(); pop();
    chk("data_1", ifc.data, 32'd1);
    pop();
    chk("data_3", ifc.data, 32'd3);
    pop();
    chk("data_7", ifc.data, 32'd7);
    pop();
    chk("data_5", ifc.data, 32'd5);
    idle();
    chk("data_4",  ifc.data,    32'd4);
    chk("sp_2",    32'(ifc.sp), 32'd2);
    push(2);
    idle();
    chk("sp_3", 32'(ifc.sp), 32'd3);

    // Drain, then fill to capacity
    pop(); pop(); pop();
    idle();
    chk("drained_empty", 32'(ifc.empty), 32'd1);
    for (int i = 0; i < int'(N); i++) push(WL'(i));
    idle();
    chk("fill_full", 32'(ifc.full), 32'd1);
    chk("fill_sp",   32'(ifc.sp),   32'd0);
    chk("fill_err",  32'(ifc.error), 32'd0);
    push(32'hdead);
    idle();
    chk("ovf_error", 32'(ifc.error), 32'd1);
    chk("ovf_sp",    32'(ifc.sp),    32'd0);
    chk("ovf_full",  32'(ifc.full),  32'd1);
    idle();
    chk("ovf_err_clear", 32'(ifc.error), 32'd0);
    pop();
    idle();
    chk("pop_after_full", ifc.data, 32'(N - 1));
    chk("sp_after_full_pop", 32'(ifc.sp), 32'(N - 1));

    // Drain to empty leaving a non-zero last popped word, then underflow
    for (int i = 0; i < int'(N) - 2; i++) pop();
    idle();
    chk("last_data", ifc.data, 32'd1);
    pop();
    idle();
    chk("last_pop_data", ifc.data, 32'd0);
    push(6); pop(); pop();
    idle();
    chk("udf_error", 32'(ifc.error), 32'd1);
    chk("udf_empty", 32'(ifc.empty), 32'd1);
    chk("udf_sp",    32'(ifc.sp),    32'd0);
    chk("udf_data",  ifc.data,       32'd6);
    drive(1'b1, 1'b1, 32'd5);
    idle();
    chk("both_error", 32'(ifc.error), 32'd1);
    chk("both_empty", 32'(ifc.empty), 32'd1);
    chk("both_data",  ifc.data,       32'd6);

    // Asynchronous reset in the middle of activity
    push(11); push(12); push(13); pop();
    push(14);
    #2 RESET = 1'b0;
    #1;
    chk("arst_sp",    32'(ifc.sp),    32'd0);
    chk("arst_empty", 32'(ifc.empty), 32'd1);
    chk("arst_data",  ifc.data,       32'd0);
    idle();
    RESET = 1'b1;
    push(9); pop();
    idle();
    chk("post_rst_data", ifc.data,    32'd9);
    chk("post_rst_sp",   32'(ifc.sp), 32'd0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
